// File: rtl/seq_mul.sv
// Sequential radix-2 shift-add multiplier. Each request takes XLEN calculate
// cycles plus one sign-fix cycle, with a valid/ready handshake on both sides.
module seq_mul #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in1,
    input  logic [XLEN-1:0]  in2,
    input  logic [1:0]       control,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int AW    = 2 * XLEN;
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        ctrl_q, ctrl_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              sign_q, sign_d;
    logic [XLEN-1:0]   out_q, out_d;
    logic [TAG_W-1:0]  out_tag_q, out_tag_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;

    logic              in1_neg, in2_neg;
    logic [XLEN-1:0]   in1_mag, in2_mag;
    logic [XLEN:0]     step_sum;
    logic [AW-1:0]     acc_fix;

    // in1 is signed for every op except mulhu; in2 only for mul/mulh.
    assign in1_neg  = (control != 2'b11) & in1[XLEN-1];
    assign in2_neg  = ~control[1] & in2[XLEN-1];
    assign in1_mag  = in1_neg ? (~in1 + XLEN'(1)) : in1;
    assign in2_mag  = in2_neg ? (~in2 + XLEN'(1)) : in2;

    // Right-shifting accumulator: add multiplicand into the upper half, shift down.
    assign step_sum = {1'b0, acc_q[AW-1:XLEN]} + (b_q[0] ? {1'b0, a_q} : '0);
    assign acc_fix  = sign_q ? (~acc_q + AW'(1)) : acc_q;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ctrl_d    = ctrl_q;
        tag_d     = tag_q;
        sign_d    = sign_q;
        out_d     = out_q;
        out_tag_d = out_tag_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in1_mag;
                    b_d     = in2_mag;
                    ctrl_d  = control;
                    tag_d   = in_tag;
                    sign_d  = in1_neg ^ in2_neg;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = {step_sum, acc_q[XLEN-1:1]};
                b_d   = b_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(XLEN - 1)) state_d = FIX;
            end
            FIX: begin
                acc_d     = acc_fix;
                out_d     = (ctrl_q == 2'b00) ? acc_fix[XLEN-1:0] : acc_fix[AW-1:XLEN];
                out_tag_d = tag_q;
                state_d   = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d   = IDLE;
            out_d     = out_q;
            out_tag_d = out_tag_q;
        end

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            ctrl_q      <= '0;
            tag_q       <= '0;
            sign_q      <= 1'b0;
            out_q       <= '0;
            out_tag_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ctrl_q      <= ctrl_d;
            tag_q       <= tag_d;
            sign_q      <= sign_d;
            out_q       <= out_d;
            out_tag_q   <= out_tag_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out       = out_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_seq_mul.sv
// Directed bench for seq_mul at XLEN=64: vector table plus handshake, flush and
// reset corner sequences.
module tb_seq_mul;

    localparam int XLEN  = 64;
    localparam int TAG_W = 5;
    localparam int LAT   = XLEN + 1;

    logic             clk = 1'b0;
    logic             rst, in_valid, in_ready, flush, out_valid, out_ready, busy;
    logic [XLEN-1:0]  in1, in2, out;
    logic [1:0]       control;
    logic [TAG_W-1:0] in_tag, out_tag;

    int n_tests = 0;
    int n_fail  = 0;

    seq_mul #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .control(control), .in_tag(in_tag),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [1:0]      ctrl;
        logic [XLEN-1:0] exp;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_state(input string name);
        check({name, " in_ready"},  in_ready,  1);
        check({name, " out_valid"}, out_valid, 0);
        check({name, " busy"},      busy,      0);
        check({name, " out"},       out,       0);
        check({name, " out_tag"},   out_tag,   0);
    endtask

    // Called at a negedge; returns at the negedge after the accept edge with
    // the operand inputs scrambled.
    task automatic start(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [1:0] c, input logic [TAG_W-1:0] t);
        int w = 0;
        while (!in_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        check("in_ready before request", in_ready, 1);
        in1 = a; in2 = b; control = c; in_tag = t; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in1      = {$urandom, $urandom};
        in2      = {$urandom, $urandom};
        control  = 2'($urandom);
        in_tag   = TAG_W'($urandom);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_vec(input string name, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           input logic [1:0] c, input logic [XLEN-1:0] exp, input logic [TAG_W-1:0] t);
        int cyc;
        start(a, b, c, t);
        wait_done(cyc);
        check({name, " latency"}, cyc, LAT);
        check({name, " out"}, out, exp);
        check({name, " out_tag"}, out_tag, t);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, " in_ready after pop"}, in_ready, 1);
        check({name, " out_valid after pop"}, out_valid, 0);
    endtask

    initial begin
        int  cyc;
        bit  seen;
        logic [XLEN-1:0]  hold_out;
        logic [TAG_W-1:0] hold_tag;

        vecs[0]  = '{64'h3, 64'hFFFF_FFFF_FFFF_FFFE, 2'b00, 64'hFFFF_FFFF_FFFF_FFFA};
        vecs[1]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[2]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[3]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b01, 64'h0};
        vecs[4]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b01, 64'h4000_0000_0000_0000};
        vecs[5]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b00, 64'h0};
        vecs[6]  = '{64'h7, 64'h6, 2'b00, 64'h2A};
        vecs[7]  = '{64'h8000_0000_0000_0000, 64'h4, 2'b11, 64'h2};
        vecs[8]  = '{64'hFFFF_FFFF_FFFF_FFFD, 64'h5, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[9]  = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFB, 2'b01, 64'h0};
        vecs[10] = '{64'h2, 64'h8000_0000_0000_0000, 2'b10, 64'h1};

        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in1 = 64'h5; in2 = 64'h5; control = 2'b00; in_tag = 5'h1F;
        repeat (3) @(negedge clk);
        check_reset_state("reset");

        // Reset released with a request already waiting: accepted on the first edge.
        rst = 1'b0;
        in_valid = 1'b0;
        run_vec("first after reset", 64'h3, 64'h5, 2'b00, 64'hF, 5'h11);

        for (int i = 0; i < 11; i++)
            run_vec($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].ctrl, vecs[i].exp, TAG_W'(i + 1));

        // Flush wins over acceptance in IDLE.
        in1 = 64'h3; in2 = 64'h3; control = 2'b00; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("flush beats accept busy", busy, 0);

        // Result held while out_ready is low; new requests ignored.
        start(64'h3, 64'hFFFF_FFFF_FFFF_FFFE, 2'b00, 5'h1A);
        wait_done(cyc);
        check("hold latency", cyc, LAT);
        hold_out = out;
        hold_tag = out_tag;
        check("hold out", hold_out, 64'hFFFF_FFFF_FFFF_FFFA);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in1 = {$urandom, $urandom}; in2 = {$urandom, $urandom};
            control = 2'($urandom); in_tag = TAG_W'($urandom); in_valid = 1'b1;
            @(negedge clk);
            if (out !== hold_out || out_tag !== hold_tag || out_valid !== 1'b1 || in_ready !== 1'b0)
                seen = 1'b1;
        end
        check("hold stable", seen, 0);
        check("hold tag", out_tag, 5'h1A);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b0;
        check("release in_ready", in_ready, 1);
        check("release no same-edge accept", busy, 0);

        // Flush mid-CALC drops the result.
        start(64'h7, 64'h6, 2'b00, 5'h03);
        repeat (20) @(negedge clk);
        check("busy before flush", busy, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush in_ready", in_ready, 1);
        check("flush busy", busy, 0);
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        check("flush no out_valid", seen, 0);
        run_vec("after flush", 64'hFFFF_FFFF_FFFF_FFF9, 64'h6, 2'b00, 64'hFFFF_FFFF_FFFF_FFD6, 5'h04);

        // Reset mid-CALC.
        start(64'h7, 64'h6, 2'b00, 5'h05);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("rst in CALC");
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 70; i++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        check("rst CALC no stale valid", seen, 0);

        // Reset while DONE.
        start(64'h9, 64'h9, 2'b11, 5'h06);
        wait_done(cyc);
        check("pre-rst DONE valid", out_valid, 1);
        out_ready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_reset_state("rst in DONE");
        rst = 1'b0;
        run_vec("after rst", 64'h9, 64'h9, 2'b00, 64'h51, 5'h07);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_mul.md
SEQ_MUL -- requirements
Module: seq_mul

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, giving operand and result width; legal values are 8 to 128, even.
REQ-002 The block SHALL have parameter TAG_W, default 5, giving the width of the pass-through tag.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 in1, in2  input  XLEN each  multiplicand and multiplier.
REQ-008 control  input  2  operation select: 00 mul (low XLEN bits, signed x signed); 01 mulh (high, signed x signed); 10 mulhsu (high, in1 signed x in2 unsigned); 11 mulhu (high, unsigned x unsigned).
REQ-009 in_tag  input  TAG_W  opaque tag captured with the request.
REQ-010 flush  input  1  abandon any in-flight operation.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 out  output  XLEN  selected half of the 2*XLEN product.
REQ-014 out_tag  output  TAG_W  tag of the request that produced out.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, CALC, FIX and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-018 Acceptance SHALL occur on an edge with in_valid & in_ready & ~flush; it latches the magnitudes of in1 and in2, control, in_tag and result sign, clears the 2*XLEN accumulator and iteration counter, and moves to CALC.
REQ-019 An operand SHALL be treated as signed only if its control selects signed: in1 for 00, 01 and 10; in2 for 00 and 01. The magnitude of a signed operand with MSB set SHALL be its two's-complement negation; -2^(XLEN-1) yields 2^(XLEN-1) as unsigned XLEN bits.
REQ-020 Result sign SHALL be (in1 signed & in1 MSB) XOR (in2 signed & in2 MSB).
REQ-021 CALC SHALL perform one radix-2 shift-add step per cycle, unsigned, on the 2*XLEN accumulator, for exactly XLEN cycles, then go to FIX; no early termination.
REQ-022 FIX SHALL take one cycle: if sign=1, negate the 2*XLEN accumulator (two's complement, so a zero product stays zero); go to DONE.
REQ-023 In DONE, out SHALL be accumulator[XLEN-1:0] for control 00, else accumulator[2*XLEN-1:XLEN]; out_tag SHALL be the latched tag.
REQ-024 out_valid SHALL first be high after the (XLEN+1)th rising edge following the acceptance edge (XLEN=64: 65 cycles).
REQ-025 In DONE, out, out_tag and out_valid SHALL hold stable until an edge with out_ready=1; on that edge go to IDLE (no same-edge acceptance of a new request).
REQ-026 Changes to in1, in2, control or in_tag after acceptance SHALL NOT affect the in-flight result.
REQ-027 flush=1 on any edge SHALL force IDLE, dropping any pending result without asserting out_valid; flush has priority over acceptance and over out_ready.
REQ-028 in_valid without in_ready SHALL be ignored, with no queuing.

Reset
REQ-029 rst=1 on an edge SHALL force IDLE, with in_ready=1, out_valid=0, busy=0, out=0, out_tag=0, accumulator and counter 0.
REQ-030 rst SHALL override flush, acceptance and out_ready, including mid-CALC and in DONE.
REQ-031 The first request SHALL be accepted on the first edge after rst deasserts.

Verification (XLEN=64)
REQ-032 mul 3 x -2 (in2=0xFFFF_FFFF_FFFF_FFFE), control 00 -> out=0xFFFF_FFFF_FFFF_FFFA, out_valid exactly 65 cycles after accept, out_tag echoes in_tag.
REQ-033 mulhu all-ones x all-ones -> 0xFFFF_FFFF_FFFF_FFFE; mulhsu in1=-1, in2=all-ones -> 0xFFFF_FFFF_FFFF_FFFF; mulh -1 x -1 -> 0.
REQ-034 mulh 0x8000_0000_0000_0000 squared -> 0x4000_0000_0000_0000; mul same operands -> 0.
REQ-035 out_ready held 0 for 10 cycles in DONE, operand inputs toggled -> out/out_tag stable, in_ready=0; after out_ready=1, in_ready=1 the next cycle.
REQ-036 flush at CALC cycle 20 -> IDLE next cycle, no out_valid; the next request computes correctly.
REQ-037 rst at CALC cycle 30 and rst while in DONE -> all outputs at reset values next cycle; no stale out_valid.
